aes_key_expander_seq: RTL and testbench

//  Sequential AES key schedule for 128/192/256-bit keys (FIPS-197 §5.2), selected per job.

---
 rtl/aes_key_expander_seq_pkg.sv | 65 ++++++
 rtl/aes_key_expander_seq_subword.sv | 12 +
 rtl/aes_key_expander_seq.sv | 191 +++++++++++++++++++
 tb/tb_aes_key_expander_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expander_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES key expander.
package aes_key_expander_seq_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CNT_W    = 6;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    return nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [8:0] key_bits_of(input key_len_e kl);
    case (kl)
      KL_128:  return 9'd128;
      KL_192:  return 9'd192;
      default: return 9'd256;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] t;
    logic [7:0] inv;
    t   = b;
    inv = 8'h01;
    for (int n = 1; n < 8; n++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expander_seq_subword.sv
// SubWord: four parallel S-boxes over one 32-bit schedule word.
module aes_key_expander_seq_subword
  import aes_key_expander_seq_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] sub_c
);

  assign sub_c = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                  sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_expander_seq.sv
// Sequential AES-128/192/256 key schedule: one word per clock, round keys over valid/ready.
// Optional AES_KEYEXP_ABORT_EN adds an abort input that drops a running job.
module aes_key_expander_seq
  import aes_key_expander_seq_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned RK_IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_KEYEXP_ABORT_EN
  input  logic                abort,
`endif
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [1:0]          key_len,
  input  logic [255:0]        key_in,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [RK_IDX_W-1:0] rk_index,
  output logic                rk_last,
  output logic                busy,
  output logic                key_err
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [0:7][WORD_W-1:0] key_q, key_d;
  logic [0:7][WORD_W-1:0] win_q, win_d;
  key_len_e               len_q, len_d;
  logic [CNT_W-1:0]       i_q, i_d;
  logic [2:0]             k_q, k_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [7:0]             rcon_q, rcon_d;
  logic                   rk_valid_q, rk_valid_d;
  logic [127:0]           rk_data_q, rk_data_d;
  logic [RK_IDX_W-1:0]    rk_index_q, rk_index_d;
  logic                   rk_last_q, rk_last_d;
  logic                   busy_q, busy_d;
  logic                   start_ready_q, start_ready_d;
  logic                   key_err_q, key_err_d;

  logic [3:0]        nk_c, nr_c;
  logic [2:0]        nk_m1_c;
  logic [CNT_W-1:0]  total_c;
  logic              past_key_c, gen_en_c, hold_c, len_bad_c;
  logic [WORD_W-1:0] prev_c, old_c, sub_in_c, sub_out_c, w_c;

  aes_key_expander_seq_subword u_subword (
    .word_i (sub_in_c),
    .sub_c  (sub_out_c)
  );

  // Next schedule word w[i]; win_q[j] holds w[i-1-j].
  always_comb begin
    nk_c       = nk_of(len_q);
    nr_c       = nr_of(len_q);
    nk_m1_c    = 3'(nk_c - 4'd1);
    total_c    = {nr_c + 4'd1, 2'b00};
    past_key_c = (i_q >= CNT_W'(nk_c));
    gen_en_c   = (i_q < total_c);
    hold_c     = (i_q[1:0] == 2'b11) && rk_valid_q && !rk_ready;
    len_bad_c  = (key_len == 2'b11) ||
                 (32'(key_bits_of(key_len_e'(key_len))) > MAX_KEY_BITS);
    prev_c     = win_q[0];
    case (len_q)
      KL_128:  old_c = win_q[3];
      KL_192:  old_c = win_q[5];
      default: old_c = win_q[7];
    endcase
    sub_in_c = (k_q == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
    if (!past_key_c)                          w_c = key_q[i_q[2:0]];
    else if (k_q == 3'd0)                     w_c = sub_out_c ^ {rcon_q, 24'h0} ^ old_c;
    else if (len_q == KL_256 && k_q == 3'd4)  w_c = sub_out_c ^ old_c;
    else                                      w_c = prev_c ^ old_c;
  end

  // FSM, word counter, window and output register next-state.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    win_d      = win_q;
    len_d      = len_q;
    i_d        = i_q;
    k_d        = k_q;
    rnd_d      = rnd_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rk_last_d  = rk_last_q;
    key_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_valid && start_ready_q) begin
          if (len_bad_c) begin
            key_err_d = 1'b1;
          end else begin
            key_d   = key_in;
            len_d   = key_len_e'(key_len);
            i_d     = '0;
            k_d     = '0;
            rnd_d   = '0;
            rcon_d  = RCON_INIT;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        if (rk_valid_q && rk_ready) begin
          rk_valid_d = 1'b0;
          rk_last_d  = 1'b0;
          if (rk_last_q) state_d = ST_IDLE;
        end
        // The window doubles as the assembly buffer; slot 3 completes a round key.
        if (gen_en_c && !hold_c) begin
          win_d = {w_c, win_q[0:6]};
          i_d   = i_q + CNT_W'(1);
          k_d   = (k_q == nk_m1_c) ? 3'd0 : k_q + 3'd1;
          if (past_key_c && k_q == 3'd0) rcon_d = xtime(rcon_q);
          if (i_q[1:0] == 2'b11) begin
            rk_valid_d = 1'b1;
            rk_data_d  = {win_q[2], win_q[1], win_q[0], w_c};
            rk_index_d = RK_IDX_W'(rnd_q);
            rk_last_d  = (rnd_q == nr_c);
            rnd_d      = rnd_q + 4'd1;
          end
        end
      end
    endcase

`ifdef AES_KEYEXP_ABORT_EN
    if (state_q == ST_RUN && abort) begin
      state_d    = ST_IDLE;
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end
`endif

    busy_d        = (state_d == ST_RUN);
    start_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      win_q         <= '0;
      len_q         <= KL_128;
      i_q           <= '0;
      k_q           <= '0;
      rnd_q         <= '0;
      rcon_q        <= RCON_INIT;
      rk_valid_q    <= 1'b0;
      rk_data_q     <= '0;
      rk_index_q    <= '0;
      rk_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
      key_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      win_q         <= win_d;
      len_q         <= len_d;
      i_q           <= i_d;
      k_q           <= k_d;
      rnd_q         <= rnd_d;
      rcon_q        <= rcon_d;
      rk_valid_q    <= rk_valid_d;
      rk_data_q     <= rk_data_d;
      rk_index_q    <= rk_index_d;
      rk_last_q     <= rk_last_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
      key_err_q     <= key_err_d;
    end
  end

  assign start_ready = start_ready_q;
  assign rk_valid    = rk_valid_q;
  assign rk_data     = rk_data_q;
  assign rk_index    = rk_index_q;
  assign rk_last     = rk_last_q;
  assign busy        = busy_q;
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq against a table-driven key schedule model.
module tb_aes_key_expander_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         busy;
  logic         key_err;
`ifdef AES_KEYEXP_ABORT_EN
  logic         abort;
`endif

  aes_key_expander_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_KEYEXP_ABORT_EN
    .abort       (abort),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_len     (key_len),
    .key_in      (key_in),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_index    (rk_index),
    .rk_last     (rk_last),
    .busy        (busy),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_tab [10];
  logic [31:0]  exp_w [60];
  logic [127:0] got_rk [15];

  logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  logic [255:0] k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] tb_sub(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Builds the S-box by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  task automatic build_model(input logic [255:0] key, input logic [1:0] len, output int nr);
    int nk;
    logic [31:0] t;
    nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        exp_w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = exp_w[i - 1];
        if (i % nk == 0) t = tb_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i / nk - 1], 24'h0};
        else if (nk == 8 && i % 8 == 4) t = tb_sub(t);
        exp_w[i] = exp_w[i - nk] ^ t;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job to completion; pct = rk_ready probability, timing checks zero-stall latency.
  task automatic run_job(input string name, input logic [255:0] key, input logic [1:0] len,
                         input int pct, input bit timing, input bit poke);
    int nr, got, e;
    bit stalled;
    logic [127:0] snap_d;
    logic [3:0]   snap_i;
    logic         snap_l;
    build_model(key, len, nr);
    key_in = key;
    key_len = len;
    start_valid = 1'b1;
    rk_ready = 1'b0;
    check_eq({name, "_start_ready"}, 128'(start_ready), 128'(1));
    step();
    start_valid = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e = 0;
    got = 0;
    stalled = 1'b0;
    snap_d = '0;
    snap_i = '0;
    snap_l = 1'b0;
    while (got <= nr && e < 3000) begin
      start_valid = 1'b0;
      if (poke && e == 6) begin
        check_eq({name, "_busy_run"}, 128'(busy), 128'(1));
        check_eq({name, "_ready_run"}, 128'(start_ready), 128'(0));
        start_valid = 1'b1;
        key_len = 2'b11;
      end
      if (poke && e == 7) check_eq({name, "_no_err_run"}, 128'(key_err), 128'(0));
      rk_ready = (pct >= 100) || ($urandom_range(99) < pct);
      if (stalled) begin
        check_eq({name, "_hold_valid"}, 128'(rk_valid), 128'(1));
        check_eq({name, "_hold_data"}, rk_data, snap_d);
        check_eq({name, "_hold_idx"}, 128'(rk_index), 128'(snap_i));
        check_eq({name, "_hold_last"}, 128'(rk_last), 128'(snap_l));
      end
      stalled = 1'b0;
      if (rk_valid) begin
        if (rk_ready) begin
          check_eq({name, "_data"}, rk_data,
                   {exp_w[4*got], exp_w[4*got+1], exp_w[4*got+2], exp_w[4*got+3]});
          check_eq({name, "_idx"}, 128'(rk_index), 128'(got));
          check_eq({name, "_last"}, 128'(rk_last), 128'(got == nr));
          if (timing) check_eq({name, "_lat"}, 128'(e), 128'(4 * (got + 1)));
          got_rk[got] = rk_data;
          got++;
        end else begin
          stalled = 1'b1;
          snap_d = rk_data;
          snap_i = rk_index;
          snap_l = rk_last;
        end
      end
      step();
      e++;
    end
    start_valid = 1'b0;
    rk_ready = 1'b0;
    check_eq({name, "_count"}, 128'(got), 128'(nr + 1));
    check_eq({name, "_end_valid"}, 128'(rk_valid), 128'(0));
    check_eq({name, "_end_busy"}, 128'(busy), 128'(0));
    check_eq({name, "_end_ready"}, 128'(start_ready), 128'(1));
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_ready"}, 128'(start_ready), 128'(1));
    check_eq({name, "_valid"}, 128'(rk_valid), 128'(0));
    check_eq({name, "_busy"}, 128'(busy), 128'(0));
    check_eq({name, "_err"}, 128'(key_err), 128'(0));
    check_eq({name, "_data"}, rk_data, 128'(0));
    check_eq({name, "_idx"}, 128'(rk_index), 128'(0));
    check_eq({name, "_last"}, 128'(rk_last), 128'(0));
  endtask

  initial begin
    logic [255:0] rkey;
    logic [1:0]   rlen;
    build_sbox();
    rst_n = 1'b0;
    start_valid = 1'b0;
    rk_ready = 1'b0;
    key_in = '0;
    key_len = 2'b00;
`ifdef AES_KEYEXP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    run_job("aes128", k128, 2'b00, 100, 1'b1, 1'b0);
    check_eq("aes128_rk0", got_rk[0], k128[255:128]);
    check_eq("aes128_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("aes128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_job("aes192", k192, 2'b01, 100, 1'b1, 1'b0);
    check_eq("aes192_w51", 128'(got_rk[12][31:0]), 128'h01002202);

    run_job("aes256", k256, 2'b10, 100, 1'b1, 1'b0);
    check_eq("aes256_w59", 128'(got_rk[14][31:0]), 128'h706c631e);

    run_job("aes128_bp", k128, 2'b00, 30, 1'b0, 1'b1);
    check_eq("aes128_bp_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Illegal key length is rejected with a single-cycle error pulse.
    key_len = 2'b11;
    key_in = k128;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    check_eq("bad_err", 128'(key_err), 128'(1));
    check_eq("bad_ready", 128'(start_ready), 128'(1));
    check_eq("bad_busy", 128'(busy), 128'(0));
    step();
    check_eq("bad_err_pulse", 128'(key_err), 128'(0));
    for (int n = 0; n < 4; n++) begin
      check_eq("bad_no_valid", 128'(rk_valid), 128'(0));
      step();
    end

    for (int j = 0; j < 6; j++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rlen = 2'($urandom_range(2));
      run_job("rand", rkey, rlen, int'($urandom_range(100, 20)), 1'b0, 1'b0);
    end

    // Reset in the middle of a job, just after rk3 is accepted.
    key_in = k128;
    key_len = 2'b00;
    start_valid = 1'b1;
    rk_ready = 1'b1;
    step();
    start_valid = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 16) check_eq("mid_rk3_idx", 128'(rk_index), 128'(3));
    end
    rst_n = 1'b0;
    rk_ready = 1'b0;
    step();
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    step();
    run_job("after_rst", k128, 2'b00, 100, 1'b1, 1'b0);
    check_eq("after_rst_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEYEXP_ABORT_EN
    key_in = k128;
    key_len = 2'b00;
    start_valid = 1'b1;
    rk_ready = 1'b1;
    step();
    start_valid = 1'b0;
    for (int e = 1; e <= 24; e++) step();
    check_eq("abort_rk5_idx", 128'(rk_index), 128'(5));
    abort = 1'b1;
    step();
    abort = 1'b0;
    rk_ready = 1'b0;
    check_eq("abort_valid", 128'(rk_valid), 128'(0));
    check_eq("abort_busy", 128'(busy), 128'(0));
    check_eq("abort_ready", 128'(start_ready), 128'(1));
    check_eq("abort_err", 128'(key_err), 128'(0));
    run_job("after_abort", k128, 2'b00, 100, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
